// File: rtl/icache_pkg.sv
// Shared types, constants and field-width helpers for the set-associative I-cache.
// Optional ICACHE_PERF_EN adds hit/miss counters on the top level.
package icache_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_FILL = 2'd1,
      S_GAP  = 2'd2
   } state_e;

   localparam logic [1:0] WB_SEL = 2'b11;
   localparam int         HW_W   = 16;

   // Byte-offset width: halfword index bits plus the ignored byte bit.
   function automatic int off_w(input int line_hw);
      return $clog2(line_hw) + 1;
   endfunction

   function automatic int idx_w(input int sets);
      return $clog2(sets);
   endfunction

   function automatic int tag_w(input int sets, input int line_hw);
      return 32 - idx_w(sets) - off_w(line_hw);
   endfunction

endpackage

// File: rtl/icache_way.sv
// One cache way: tag, valid and line data arrays with two combinational line reads,
// a single halfword/tag write port and a bulk valid clear.
module icache_way
   import icache_pkg::*;
#(
   parameter int SETS    = 128,
   parameter int LINE_HW = 16,
   parameter int IDX_W   = 7,
   parameter int TAG_W   = 20,
   parameter int CNT_W   = 4
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      clr_i,
   input  logic [IDX_W-1:0]          rd_a_set_i,
   output logic                      rd_a_vld_o,
   output logic [TAG_W-1:0]          rd_a_tag_o,
   output logic [LINE_HW*HW_W-1:0]   rd_a_line_o,
   input  logic [IDX_W-1:0]          rd_b_set_i,
   output logic                      rd_b_vld_o,
   output logic [TAG_W-1:0]          rd_b_tag_o,
   output logic [LINE_HW*HW_W-1:0]   rd_b_line_o,
   input  logic [IDX_W-1:0]          wr_set_i,
   output logic                      wr_vld_o,
   input  logic                      wr_en_i,
   input  logic [CNT_W-1:0]          wr_off_i,
   input  logic [HW_W-1:0]           wr_dat_i,
   input  logic                      tag_we_i,
   input  logic [TAG_W-1:0]          wr_tag_i
);

   logic [SETS-1:0]                r_valid;
   logic [TAG_W-1:0]               r_tag  [SETS];
   logic [LINE_HW-1:0][HW_W-1:0]   r_data [SETS];

   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         r_valid <= '0;
      end else if (tag_we_i) begin
         r_valid[wr_set_i] <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (tag_we_i) begin
         r_tag[wr_set_i] <= wr_tag_i;
      end
      if (wr_en_i) begin
         r_data[wr_set_i][wr_off_i] <= wr_dat_i;
      end
   end

   assign rd_a_vld_o  = r_valid[rd_a_set_i];
   assign rd_a_tag_o  = r_tag[rd_a_set_i];
   assign rd_a_line_o = r_data[rd_a_set_i];
   assign rd_b_vld_o  = r_valid[rd_b_set_i];
   assign rd_b_tag_o  = r_tag[rd_b_set_i];
   assign rd_b_line_o = r_data[rd_b_set_i];
   assign wr_vld_o    = r_valid[wr_set_i];

endmodule

// File: rtl/icache_sa.sv
// Set-associative instruction cache returning a 48-bit fetch window that may span two lines.
// Define ICACHE_PERF_EN to add the hit_cnt_o / miss_cnt_o counters.
module icache_sa
   import icache_pkg::*;
#(
   parameter int SETS    = 128,
   parameter int WAYS    = 2,
   parameter int LINE_HW = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] adr_i,
   input  logic        stb_i,
   input  logic        flush_i,
   output logic        hit_o,
   output logic [15:0] inst_o,
   output logic [31:0] data_o,
   output logic [31:0] wb_adr_o,
   input  logic [15:0] wb_dat_i,
   output logic [1:0]  wb_sel_o,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   input  logic        wb_ack_i,
`ifdef ICACHE_PERF_EN
   output logic [31:0] hit_cnt_o,
   output logic [31:0] miss_cnt_o,
`endif
   output logic [1:0]  dbg_state_o
);

   localparam int OFF_W = off_w(LINE_HW);
   localparam int IDX_W = idx_w(SETS);
   localparam int TAG_W = tag_w(SETS, LINE_HW);
   localparam int CNT_W = OFF_W - 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_HW - 1);
   localparam logic [1:0] ST_IDLE = S_IDLE;
   localparam logic [1:0] ST_FILL = S_FILL;
   localparam logic [1:0] ST_GAP  = S_GAP;

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [31:0]      r_wb_adr;
   logic             r_wb_stb;
   logic [TAG_W-1:0] r_tag_a, r_tag_b;
   logic [IDX_W-1:0] r_set_a, r_set_b;
   logic             r_miss_a, r_miss_b, r_cur_b, r_flush_pend;
   logic [SETS-1:0]  r_lru;

   // Halfword addresses of the three window slots; +2 wraps like a 32-bit byte address.
   logic [30:0] w_hw0, w_hw1, w_hw2;
   assign w_hw0 = 31'((adr_i & 32'hFFFF_FFFE) >> 1);
   assign w_hw1 = w_hw0 + 31'd1;
   assign w_hw2 = w_hw0 + 31'd2;

   logic [TAG_W-1:0] w_tag_a, w_tag_b;
   logic [IDX_W-1:0] w_set_a, w_set_b;
   logic             w_need_b, w_in_a1;
   assign w_tag_a  = w_hw0[30 -: TAG_W];
   assign w_set_a  = w_hw0[OFF_W-1 +: IDX_W];
   assign w_tag_b  = w_hw2[30 -: TAG_W];
   assign w_set_b  = w_hw2[OFF_W-1 +: IDX_W];
   assign w_need_b = (w_hw2[30:OFF_W-1] != w_hw0[30:OFF_W-1]);
   assign w_in_a1  = (w_hw1[30:OFF_W-1] == w_hw0[30:OFF_W-1]);

   logic [WAYS-1:0]           w_vld_a, w_vld_b, w_vld_f, w_hit_va, w_hit_vb, w_victim;
   logic [TAG_W-1:0]          w_tag_ra  [WAYS];
   logic [TAG_W-1:0]          w_tag_rb  [WAYS];
   logic [LINE_HW*HW_W-1:0]   w_line_ra [WAYS];
   logic [LINE_HW*HW_W-1:0]   w_line_rb [WAYS];
   logic [LINE_HW-1:0][HW_W-1:0] w_line_a, w_line_b;

   logic [IDX_W-1:0] w_fill_set;
   logic [TAG_W-1:0] w_fill_tag;
   logic             w_fill_we, w_fill_last, w_gap_to_fill, w_clr;
   logic             w_hit_a, w_hit_b, w_hit, w_way_a, w_victim_idx, w_found;

   assign w_fill_set    = r_cur_b ? r_set_b : r_set_a;
   assign w_fill_tag    = r_cur_b ? r_tag_b : r_tag_a;
   assign w_fill_we     = (r_state == ST_FILL) && wb_ack_i && !rst_i;
   assign w_fill_last   = w_fill_we && (r_cnt == CNT_LAST);
   assign w_gap_to_fill = (r_state == ST_GAP) && !r_cur_b && r_miss_b;
   assign w_clr = ((r_state == ST_IDLE) && flush_i) ||
                  ((r_state == ST_GAP) && !w_gap_to_fill && (r_flush_pend || flush_i));

   for (genvar g = 0; g < WAYS; g++) begin : g_way
      icache_way #(
         .SETS(SETS), .LINE_HW(LINE_HW), .IDX_W(IDX_W), .TAG_W(TAG_W), .CNT_W(CNT_W)
      ) u_way (
         .clk_i       (clk_i),
         .rst_i       (rst_i),
         .clr_i       (w_clr),
         .rd_a_set_i  (w_set_a),
         .rd_a_vld_o  (w_vld_a[g]),
         .rd_a_tag_o  (w_tag_ra[g]),
         .rd_a_line_o (w_line_ra[g]),
         .rd_b_set_i  (w_set_b),
         .rd_b_vld_o  (w_vld_b[g]),
         .rd_b_tag_o  (w_tag_rb[g]),
         .rd_b_line_o (w_line_rb[g]),
         .wr_set_i    (w_fill_set),
         .wr_vld_o    (w_vld_f[g]),
         .wr_en_i     (w_fill_we && w_victim[g]),
         .wr_off_i    (r_cnt),
         .wr_dat_i    (wb_dat_i),
         .tag_we_i    (w_fill_last && w_victim[g]),
         .wr_tag_i    (w_fill_tag)
      );
   end

   always_comb begin
      w_hit_va = '0;
      w_hit_vb = '0;
      w_line_a = '0;
      w_line_b = '0;
      for (int w = 0; w < WAYS; w++) begin
         w_hit_va[w] = w_vld_a[w] && (w_tag_ra[w] == w_tag_a);
         w_hit_vb[w] = w_vld_b[w] && (w_tag_rb[w] == w_tag_b);
         if (w_hit_va[w]) w_line_a = w_line_ra[w];
         if (w_hit_vb[w]) w_line_b = w_line_rb[w];
      end
   end

   assign w_hit_a = |w_hit_va;
   assign w_hit_b = |w_hit_vb;
   assign w_hit   = w_hit_a && (!w_need_b || w_hit_b) && !rst_i && !flush_i;
   assign w_way_a = (WAYS == 2) && w_hit_va[WAYS-1];

   assign hit_o  = w_hit;
   assign inst_o = w_line_a[w_hw0[CNT_W-1:0]];
   assign data_o = {(w_in_a1  ? w_line_a[w_hw1[CNT_W-1:0]] : w_line_b[w_hw1[CNT_W-1:0]]),
                    (!w_need_b ? w_line_a[w_hw2[CNT_W-1:0]] : w_line_b[w_hw2[CNT_W-1:0]])};

   // Lowest invalid way first; with every way valid fall back to the set's LRU bit.
   always_comb begin
      w_victim = '0;
      w_found  = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
         if (!w_found && !w_vld_f[w]) begin
            w_victim[w] = 1'b1;
            w_found     = 1'b1;
         end
      end
      if (!w_found) begin
         for (int w = 0; w < WAYS; w++) begin
            w_victim[w] = (WAYS == 1) || (r_lru[w_fill_set] == w[0]);
         end
      end
   end
   assign w_victim_idx = (WAYS == 2) && w_victim[WAYS-1];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_wb_adr     <= '0;
         r_wb_stb     <= 1'b0;
         r_tag_a      <= '0;
         r_tag_b      <= '0;
         r_set_a      <= '0;
         r_set_b      <= '0;
         r_miss_a     <= 1'b0;
         r_miss_b     <= 1'b0;
         r_cur_b      <= 1'b0;
         r_flush_pend <= 1'b0;
         r_lru        <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (stb_i && w_hit) begin
                  r_lru[w_set_a] <= !w_way_a;
               end else if (stb_i) begin
                  r_tag_a  <= w_tag_a;
                  r_set_a  <= w_set_a;
                  r_tag_b  <= w_tag_b;
                  r_set_b  <= w_set_b;
                  r_miss_a <= !w_hit_a || flush_i;
                  r_miss_b <= w_need_b && (!w_hit_b || flush_i);
                  r_cur_b  <= !(!w_hit_a || flush_i);
                  r_wb_adr <= (!w_hit_a || flush_i) ? {w_tag_a, w_set_a, {OFF_W{1'b0}}}
                                                     : {w_tag_b, w_set_b, {OFF_W{1'b0}}};
                  r_wb_stb <= 1'b1;
                  r_cnt    <= '0;
                  r_state  <= ST_FILL;
               end
            end
            ST_FILL: begin
               if (flush_i) r_flush_pend <= 1'b1;
               if (w_fill_we) begin
                  r_cnt    <= r_cnt + 1'b1;
                  r_wb_adr <= r_wb_adr + 32'd2;
                  if (r_cnt == CNT_LAST) begin
                     r_wb_stb          <= 1'b0;
                     r_state           <= ST_GAP;
                     r_lru[w_fill_set] <= !w_victim_idx;
                     if (r_cur_b) r_miss_b <= 1'b0;
                     else         r_miss_a <= 1'b0;
                  end
               end
            end
            ST_GAP: begin
               if (w_gap_to_fill) begin
                  if (flush_i) r_flush_pend <= 1'b1;
                  r_cur_b  <= 1'b1;
                  r_wb_adr <= {r_tag_b, r_set_b, {OFF_W{1'b0}}};
                  r_wb_stb <= 1'b1;
                  r_cnt    <= '0;
                  r_state  <= ST_FILL;
               end else begin
                  r_flush_pend <= 1'b0;
                  r_state      <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

`ifdef ICACHE_PERF_EN
   logic [31:0] r_hit_cnt, r_miss_cnt;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else if (r_state == ST_IDLE && stb_i) begin
         if (w_hit) r_hit_cnt  <= r_hit_cnt + 32'd1;
         else       r_miss_cnt <= r_miss_cnt + 32'd1;
      end
   end

   assign hit_cnt_o  = r_hit_cnt;
   assign miss_cnt_o = r_miss_cnt;
`endif

   assign wb_sel_o    = WB_SEL;
   assign wb_cyc_o    = r_wb_stb;
   assign wb_stb_o    = r_wb_stb;
   assign wb_adr_o    = r_wb_adr;
   assign dbg_state_o = r_state;

endmodule

// File: tb/tb_icache_sa.sv
// Directed bench for icache_sa (SETS=128, WAYS=2, LINE_HW=16) with a Wishbone memory
// that acks every cycle and a scoreboard of expected bus addresses.
module tb_icache_sa;

   logic        clk = 1'b0;
   logic        rst, stb, flush;
   logic [31:0] adr;
   logic        hit;
   logic [15:0] inst;
   logic [31:0] data;
   logic [31:0] wb_adr;
   logic [15:0] wb_dat;
   logic [1:0]  wb_sel;
   logic        wb_cyc, wb_stb, wb_ack;
   logic [1:0]  dbg_state;
`ifdef ICACHE_PERF_EN
   logic [31:0] hit_cnt, miss_cnt;
`endif

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_q[$];
   logic [31:0] mon_exp;

   always #5 clk = ~clk;

   icache_sa #(.SETS(128), .WAYS(2), .LINE_HW(16)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .adr_i       (adr),
      .stb_i       (stb),
      .flush_i     (flush),
      .hit_o       (hit),
      .inst_o      (inst),
      .data_o      (data),
      .wb_adr_o    (wb_adr),
      .wb_dat_i    (wb_dat),
      .wb_sel_o    (wb_sel),
      .wb_cyc_o    (wb_cyc),
      .wb_stb_o    (wb_stb),
      .wb_ack_i    (wb_ack),
`ifdef ICACHE_PERF_EN
      .hit_cnt_o   (hit_cnt),
      .miss_cnt_o  (miss_cnt),
`endif
      .dbg_state_o (dbg_state)
   );

   function automatic logic [15:0] mem_hw(input logic [31:0] a);
      return a[16:1] ^ a[31:16] ^ 16'h3C5A;
   endfunction

   always_comb wb_dat = mem_hw(wb_adr);
   assign wb_ack = wb_stb;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Every accepted beat must match the next expected bus address.
   always @(negedge clk) begin
      if (wb_stb && wb_ack) begin
         if (exp_q.size() > 0) mon_exp = exp_q.pop_front();
         else                  mon_exp = 32'hDEAD_BEEF;
         check("bus_adr", 64'(wb_adr), 64'(mon_exp));
         check("bus_cyc_sel", 64'({wb_cyc, wb_sel}), 64'(3'b111));
      end
   end

   task automatic push_line(input logic [31:0] base);
      for (int i = 0; i < 16; i++) exp_q.push_back(base + 32'(2 * i));
   endtask

   task automatic flush_pulse();
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
   endtask

   task automatic fetch(input string tag, input logic [31:0] a, input int exp_wait);
      int waited;
      waited = 0;
      @(negedge clk);
      adr = a;
      stb = 1'b1;
      #1;
      while (!hit && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      check({tag, "_hit"}, 64'(hit), 64'(1));
      check({tag, "_wait"}, 64'(waited), 64'(exp_wait));
      check({tag, "_inst"}, 64'(inst), 64'(mem_hw(a)));
      check({tag, "_data"}, 64'(data), 64'({mem_hw(a + 32'd2), mem_hw(a + 32'd4)}));
      @(negedge clk);
      stb = 1'b0;
   endtask

   initial begin
      int waited;
      rst   = 1'b1;
      stb   = 1'b0;
      flush = 1'b0;
      adr   = 32'h0;
      repeat (3) @(negedge clk);
      check("rst_stb", 64'(wb_stb), 64'(0));
      check("rst_cyc", 64'(wb_cyc), 64'(0));
      check("rst_adr", 64'(wb_adr), 64'(0));
      check("rst_hit", 64'(hit), 64'(0));
      check("rst_state", 64'(dbg_state), 64'(0));
      rst = 1'b0;

      push_line(32'h100);
      fetch("cold_100", 32'h100, 17);
      check("idle_stb", 64'(wb_stb), 64'(0));

      flush_pulse();
      adr = 32'h100;
      #1;
      check("flushed_100", 64'(hit), 64'(0));

      push_line(32'h100);
      push_line(32'h120);
      fetch("span_11c", 32'h11C, 34);

      push_line(32'h0000);
      push_line(32'h1000);
      push_line(32'h2000);
      push_line(32'h1000);
      fetch("lru_0000", 32'h0000, 17);
      fetch("lru_1000", 32'h1000, 17);
      fetch("lru_0000_re", 32'h0000, 0);
      fetch("lru_2000", 32'h2000, 17);
      fetch("lru_0000_keep", 32'h0000, 0);
      fetch("lru_1000_evict", 32'h1000, 17);

      flush_pulse();
      push_line(32'hFFFF_FFE0);
      push_line(32'h0000_0000);
      fetch("wrap", 32'hFFFF_FFFC, 34);

      push_line(32'h200);
      push_line(32'h200);
      @(negedge clk);
      adr = 32'h200;
      stb = 1'b1;
      repeat (5) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      waited = 6;
      while (!hit && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      check("mid_flush_hit", 64'(hit), 64'(1));
      check("mid_flush_wait", 64'(waited), 64'(17));
      @(negedge clk);
      check("mid_flush_gone", 64'(hit), 64'(0));
      stb = 1'b0;
      fetch("refetch_200", 32'h200, 17);

`ifdef ICACHE_PERF_EN
      check("perf_hits", 64'(hit_cnt), 64'(2));
      check("perf_misses", 64'(miss_cnt), 64'(9));
`endif

      for (int i = 0; i < 6; i++) exp_q.push_back(32'h300 + 32'(2 * i));
      @(negedge clk);
      adr = 32'h300;
      stb = 1'b1;
      repeat (6) @(negedge clk);
      #1;
      rst = 1'b1;
      stb = 1'b0;
      @(negedge clk);
      check("beat_rst_stb", 64'(wb_stb), 64'(0));
      check("beat_rst_cyc", 64'(wb_cyc), 64'(0));
      check("beat_rst_hit", 64'(hit), 64'(0));
      check("beat_rst_adr", 64'(wb_adr), 64'(0));
      check("beat_rst_state", 64'(dbg_state), 64'(0));
`ifdef ICACHE_PERF_EN
      check("beat_rst_hitcnt", 64'(hit_cnt), 64'(0));
      check("beat_rst_misscnt", 64'(miss_cnt), 64'(0));
`endif
      rst = 1'b0;
      @(negedge clk);
      adr = 32'h100;
      #1;
      check("post_rst_cold", 64'(hit), 64'(0));
      repeat (3) @(negedge clk);
      check("post_rst_idle", 64'(wb_stb), 64'(0));
      check("bus_q_empty", 64'(exp_q.size()), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
